// File: rtl/barrel_rotate_sequencer_pkg.sv
// Shared types and width helpers for the nibble-serial word rotator.
package barrel_rotate_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIB_DEF = 4;

  function automatic int unsigned word_w(input int unsigned nib);
    return 4 * nib;
  endfunction

  function automatic int unsigned amt_w(input int unsigned nib);
    return $clog2(4 * nib);
  endfunction

endpackage

// File: rtl/barrel_rotate_sequencer_shifter.sv
// 4-bit window shifter: picks a 4-bit slice of a 7-bit window at offset i_sel.
module Four_Bit_Barrel_Shifter (
  input  logic [6:0] i_win,
  input  logic [1:0] i_sel,
  output logic [3:0] o_slice
);

  always_comb begin
    o_slice = i_win[i_sel +: 4];
  end

endmodule

// File: rtl/barrel_rotate_sequencer.sv
// Multi-cycle W-bit rotator producing one result nibble per cycle through a
// single shared 4-bit window shifter; valid/ready on both sides.
module barrel_rotate_sequencer
  import barrel_rotate_sequencer_pkg::*;
#(
  parameter  int unsigned NIB = NIB_DEF,
  localparam int unsigned W   = word_w(NIB),
  localparam int unsigned AW  = amt_w(NIB),
  localparam int unsigned KW  = $clog2(NIB)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy
);

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_op;
  logic [AW-1:0] r_amt;
  logic [W-1:0]  r_result;
  logic [KW-1:0] r_k;
  logic [AW-1:0] w_base;
  logic [6:0]    w_win;
  logic [3:0]    w_slice;
  logic          w_last;

  assign w_last = (r_k == KW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, whatever state is registered.
  always_comb begin
    in_ready  = ~rst & (r_state == IDLE);
    busy      = ~rst & (r_state != IDLE);
    out_valid = ~rst & (r_state == DONE);
    out_data  = rst ? '0 : r_result;
  end

  // Left rotate by n is a right rotate by (W - n) mod W; 2^AW wrap gives the mod.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_amt    <= '0;
      r_result <= '0;
      r_k      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op  <= in_data;
            r_amt <= in_dir ? (AW'(0) - in_amt) : in_amt;
            r_k   <= '0;
          end
        end
        RUN: begin
          r_result[{r_k, 2'b00} +: 4] <= w_slice;
          r_k                         <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Window starts at nibble k plus the whole-nibble part of the amount, wrapping mod W.
  always_comb begin
    w_base = {r_k, 2'b00} + {r_amt[AW-1:2], 2'b00};
    w_win  = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      w_win[i] = r_op[w_base + AW'(i)];
    end
  end

  Four_Bit_Barrel_Shifter u_shifter (
    .i_win   (w_win),
    .i_sel   (r_amt[1:0]),
    .o_slice (w_slice)
  );

endmodule

// File: tb/tb_barrel_rotate_sequencer.sv
// Self-checking bench for barrel_rotate_sequencer against a plain rotate model.
module tb_barrel_rotate_sequencer;

  localparam int NIB = 4;
  localparam int W   = 16;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic          in_dir = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  barrel_rotate_sequencer #(.NIB(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d, input int amt, input logic dir);
    logic [2*W-1:0] dd;
    logic [W-1:0]   r;
    dd = {d, d};
    if (!dir) begin
      dd = dd >> amt;
      r  = dd[W-1:0];
    end else begin
      dd = dd << amt;
      r  = dd[2*W-1:W];
    end
    return r;
  endfunction

  // Issues one request from an IDLE negedge with out_ready already high; returns
  // the result and the cycle (relative to the handshake) in which out_valid rose.
  task automatic run_op(input logic [W-1:0] d, input logic [AW-1:0] a, input logic dir,
                        output logic [W-1:0] got, output int lat);
    lat      = -1;
    got      = '0;
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    in_valid = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = n;
        got = out_data;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, out_data} !== '0)
      begin n_bad++; $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b data=%h required all 0", in_ready, out_valid, busy, out_data); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, busy, out_valid} !== 3'b100)
      begin n_bad++; $display("FAIL reset_release: got rdy=%b busy=%b vld=%b required 1 0 0", in_ready, busy, out_valid); end
  endtask

  task automatic test_right_rotates;
    logic [W-1:0] got;
    int lat;
    out_ready = 1'b1;
    run_op(16'h1234, 4'd0, 1'b0, got, lat);
    n_cmp++; if (got !== 16'h1234) begin n_bad++; $display("FAIL rot_r0: got %h required %h", got, 16'h1234); end
    n_cmp++; if (lat !== NIB + 1) begin n_bad++; $display("FAIL latency: got %0d required %0d", lat, NIB + 1); end
    run_op(16'h1234, 4'd4, 1'b0, got, lat);
    n_cmp++; if (got !== 16'h4123) begin n_bad++; $display("FAIL rot_r4: got %h required %h", got, 16'h4123); end
    run_op(16'h1234, 4'd1, 1'b0, got, lat);
    n_cmp++; if (got !== 16'h091A) begin n_bad++; $display("FAIL rot_r1: got %h required %h", got, 16'h091A); end
  endtask

  task automatic test_wrap_left;
    logic [W-1:0] got;
    int lat;
    out_ready = 1'b1;
    run_op(16'h8001, 4'd15, 1'b0, got, lat);
    n_cmp++; if (got !== 16'h0003) begin n_bad++; $display("FAIL rot_r15_wrap: got %h required %h", got, 16'h0003); end
    run_op(16'h1234, 4'd4, 1'b1, got, lat);
    n_cmp++; if (got !== 16'h2341) begin n_bad++; $display("FAIL rot_l4: got %h required %h", got, 16'h2341); end
    run_op(16'hA5C3, 4'd0, 1'b1, got, lat);
    n_cmp++; if (got !== 16'hA5C3) begin n_bad++; $display("FAIL rot_l0: got %h required %h", got, 16'hA5C3); end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] exp, held;
    bit seen;
    exp = ref_rot(16'hBEEF, 7, 1'b0);
    seen = 1'b0;
    held = '0;
    out_ready = 1'b0;
    in_data = 16'hBEEF; in_amt = 4'd7; in_dir = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin seen = 1'b1; held = out_data; end
    end
    n_cmp++;
    if (!seen || held !== exp)
      begin n_bad++; $display("FAIL bp_result: got valid=%b data=%h required valid=1 data=%h", seen, held, exp); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp})
        begin n_bad++; $display("FAIL bp_hold: got vld=%b rdy=%b data=%h required 1 0 %h", out_valid, in_ready, out_data, exp); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10)
      begin n_bad++; $display("FAIL bp_release: got rdy=%b vld=%b required 1 0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    int last, caps;
    last = -1;
    caps = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (out_data !== e) begin n_bad++; $display("FAIL b2b_data: got %h required %h", out_data, e); end
      end
      in_data = W'($urandom);
      in_amt  = AW'($urandom_range(0, W - 1));
      in_dir  = 1'($urandom_range(0, 1));
      if (in_ready) begin
        exp_q.push_back(ref_rot(in_data, int'(in_amt), in_dir));
        caps++;
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last !== NIB + 2) begin n_bad++; $display("FAIL b2b_interval: got %0d required %0d", cyc - last, NIB + 2); end
        end
        last = cyc;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e) begin n_bad++; $display("FAIL b2b_drain: got %h required %h", out_data, e); end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0 || caps < 9)
      begin n_bad++; $display("FAIL b2b_count: got pending=%0d captures=%0d required 0 and >=9", exp_q.size(), caps); end
    while (!in_ready) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] got;
    int lat;
    bit bad_seen;
    out_ready = 1'b1;
    in_data = 16'hF00F; in_amt = 4'd3; in_dir = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, out_data} !== '0)
      begin n_bad++; $display("FAIL midrst_outputs: got rdy=%b vld=%b busy=%b data=%h required all 0", in_ready, out_valid, busy, out_data); end
    rst = 1'b0;
    bad_seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid || !in_ready || out_data !== '0) bad_seen = 1'b1;
    end
    n_cmp++;
    if (bad_seen)
      begin n_bad++; $display("FAIL midrst_discard: got stray valid/busy/nonzero data after reset required idle with data 0"); end
    run_op(16'h0F1E, 4'd6, 1'b1, got, lat);
    n_cmp++;
    if (got !== ref_rot(16'h0F1E, 6, 1'b1) || lat !== NIB + 1)
      begin n_bad++; $display("FAIL midrst_fresh: got %h lat %0d required %h lat %0d", got, lat, ref_rot(16'h0F1E, 6, 1'b1), NIB + 1); end
  endtask

  task automatic test_random;
    logic [W-1:0] exp;
    bit done;
    for (int it = 0; it < 1000; it++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rnd_ready: got %b required 1 (iter %0d)", in_ready, it); end
      in_data  = W'($urandom);
      in_amt   = AW'($urandom_range(0, W - 1));
      in_dir   = 1'($urandom_range(0, 1));
      exp      = ref_rot(in_data, int'(in_amt), in_dir);
      in_valid = 1'b1;
      done     = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = ($urandom_range(0, 3) == 0);
        in_data   = W'($urandom);
        in_amt    = AW'($urandom);
        in_dir    = 1'($urandom);
        if (out_valid) begin
          n_cmp++;
          if (out_data !== exp) begin n_bad++; $display("FAIL rnd_data: got %h required %h (iter %0d)", out_data, exp, it); end
          if (out_ready) begin
            in_valid = 1'b0;
            done = 1'b1;
            @(negedge clk);
          end
        end
      end
      if (!done) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_timeout: got no completed handshake required one within 40 cycles (iter %0d)", it);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_right_rotates;
    test_wrap_left;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
